if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 144 ++++++++++++++
 tb/tb_if_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage.
// Fetches through a request/grant/rvalid instruction memory port. Up to two
// fetches are kept in flight, and the 2-entry instruction FIFO is never
// overrun. A redirect flushes the FIFO, and any responses still outstanding
// are dropped.
// Optional build macro IF_MISALIGN_TRAP_EN: a misaligned redirect target
// raises misalign and halts fetch until an aligned redirect arrives.
// Without the macro, npc[1:0] is ignored and misalign stays 0.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        misalign
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc;
  logic [1:0]  inflight;
  logic [1:0]  drop;
  logic [1:0]  fifo_count;
  logic        misalign_q;

  // in-flight address queue (issue order == response order)
  logic [31:0] aq [2];
  logic        aq_wp, aq_rp;

  // instruction FIFO: fetched word plus its address
  logic [31:0] fq_instr [2];
  logic [31:0] fq_pc    [2];
  logic        fq_wp, fq_rp;

  logic        issue, resp, discard, accept, pop;
  logic        redir_mis;
  logic [31:0] npc_eff;
  logic [1:0]  drop_on_redir;
  logic        credit_ok;

`ifdef IF_MISALIGN_TRAP_EN
  assign redir_mis = redirect & (npc[1:0] != 2'b00);
  assign npc_eff   = npc;
`else
  assign redir_mis = 1'b0;
  assign npc_eff   = npc & 32'hFFFF_FFFC;
`endif

  assign credit_ok     = ({1'b0, inflight} + {1'b0, fifo_count}) < 3'd2;
  assign issue         = imem_req & imem_gnt;
  assign resp          = imem_rvalid;
  assign discard       = resp & (drop != 2'd0);
  assign accept        = resp & (drop == 2'd0) & (state != HALT);
  assign pop           = instr_valid & id_ready & ~redirect;
  // a response landing in the redirect cycle is already dropped by the flush
  assign drop_on_redir = inflight - {1'b0, resp};

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // next-state: redirect has priority, DRAIN ends when the last stale response is dropped
  always_comb begin
    state_nx = state;
    if (redirect) begin
      if (redir_mis)                   state_nx = HALT;
      else if (drop_on_redir != 2'd0)  state_nx = DRAIN;
      else                             state_nx = RUN;
    end else begin
      unique case (state)
        DRAIN:   if (discard && drop == 2'd1) state_nx = RUN;
        HALT:    state_nx = HALT;
        default: state_nx = RUN;
      endcase
    end
  end

  // outputs: request gating and FIFO head presentation
  always_comb begin
    imem_req    = ~rst & (state != HALT) & ~redirect & credit_ok;
    imem_addr   = fetch_pc;
    instr_valid = (fifo_count != 2'd0);
    instr       = fq_instr[fq_rp];
    pc          = fq_pc[fq_rp];
    misalign    = misalign_q;
  end

  // datapath: fetch PC, counters, address queue and instruction FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      inflight   <= '0;
      drop       <= '0;
      fifo_count <= '0;
      misalign_q <= 1'b0;
      aq_wp      <= 1'b0;
      aq_rp      <= 1'b0;
      fq_wp      <= 1'b0;
      fq_rp      <= 1'b0;
      fq_instr   <= '{default: '0};
      fq_pc      <= '{default: RESET_PC};
    end else begin
      if (issue) begin
        aq[aq_wp] <= fetch_pc;
        aq_wp     <= ~aq_wp;
      end
      if (resp) aq_rp <= ~aq_rp;
      inflight <= inflight + {1'b0, issue} - {1'b0, resp};

      if (redirect) begin
        fetch_pc   <= npc_eff;
        drop       <= drop_on_redir;
        fifo_count <= '0;
        fq_wp      <= 1'b0;
        fq_rp      <= 1'b0;
        misalign_q <= redir_mis;
      end else begin
        if (issue)   fetch_pc <= fetch_pc + 32'd4;
        if (discard) drop     <= drop - 2'd1;
        if (accept) begin
          fq_instr[fq_wp] <= imem_rdata;
          fq_pc[fq_wp]    <= aq[aq_rp];
          fq_wp           <= ~fq_wp;
        end
        if (pop) fq_rp <= ~fq_rp;
        fifo_count <= fifo_count + {1'b0, accept} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test of if_stage against a 1-cycle-latency memory stub.
// Memory word at address a is a ^ 32'hDEAD_0000.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, redirect, imem_gnt, imem_rvalid, id_ready;
  logic [31:0] npc, imem_rdata;
  logic        imem_req, instr_valid, misalign;
  logic [31:0] imem_addr, instr, pc;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic        rv_en;
  logic [31:0] pend [$];

  if_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .npc(npc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_ready(id_ready),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: drive memory response, record grant, sample #1 after the edge
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    imem_rvalid = rv_en && (pend.size() != 0);
    imem_rdata  = imem_rvalid ? (pend[0] ^ 32'hDEAD_0000) : '0;
    #1;
    fire = imem_req & imem_gnt;
    a    = imem_addr;
    @(posedge clk);
    if (imem_rvalid) void'(pend.pop_front());
    if (fire) pend.push_back(a);
    #1;
  endtask

  task automatic do_reset();
    pend.delete();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; npc = '0; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b1; rv_en = 1'b1;
    @(negedge clk);

    // reset values, rst still asserted
    tick(); tick();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            32'h0000_3000);
    chk("rst_pc",    pc,                   32'h0000_3000);
    chk("rst_instr", instr,                32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_mis",   {31'd0, misalign},    32'd0);
    rst = 1'b0; #1;
    chk("req_after_rst", {31'd0, imem_req}, 32'd1);

    // streaming fetch from reset
    tick(); chk("s1_c0_valid", {31'd0, instr_valid}, 32'd0);
            chk("s1_c0_addr",  imem_addr, 32'h0000_3004);
    tick(); chk("s1_c1_valid", {31'd0, instr_valid}, 32'd1);
            chk("s1_c1_pc",    pc,    32'h0000_3000);
            chk("s1_c1_instr", instr, 32'hDEAD_3000);
            chk("s1_c1_addr",  imem_addr, 32'h0000_3008);
    tick(); chk("s1_c2_pc",    pc, 32'h0000_3004);
            chk("s1_c2_req",   {31'd0, imem_req}, 32'd1);
    tick(); chk("s1_c3_valid", {31'd0, instr_valid}, 32'd0);
            chk("s1_c3_addr",  imem_addr, 32'h0000_300C);
    tick(); chk("s1_c4_pc",    pc, 32'h0000_3008);

    // decode stalled for 5 cycles: FIFO fills, requests stop
    do_reset();
    id_ready = 1'b0;
    repeat (5) tick();
    chk("s2_req_stall", {31'd0, imem_req}, 32'd0);
    chk("s2_valid",     {31'd0, instr_valid}, 32'd1);
    chk("s2_pc0",       pc,    32'h0000_3000);
    chk("s2_instr0",    instr, 32'hDEAD_3000);
    id_ready = 1'b1;
    tick(); chk("s2_pc1",    pc,    32'h0000_3004);
            chk("s2_instr1", instr, 32'hDEAD_3004);
    tick(); chk("s2_empty",  {31'd0, instr_valid}, 32'd0);
            chk("s2_addr",   imem_addr, 32'h0000_300C);

    // redirect with two fetches in flight
    rv_en = 1'b0;
    tick(); chk("s3_addr2", imem_addr, 32'h0000_3010);
            chk("s3_full",  {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; npc = 32'h0000_3100; #1;
    chk("s3_req_redir", {31'd0, imem_req}, 32'd0);
    tick(); redirect = 1'b0; rv_en = 1'b1;
    chk("s3_flush", {31'd0, instr_valid}, 32'd0);
    chk("s3_npc",   imem_addr, 32'h0000_3100);
    tick(); chk("s3_drop1", {31'd0, instr_valid}, 32'd0);
            chk("s3_req_drain", {31'd0, imem_req}, 32'd1);
    tick(); chk("s3_drop2", {31'd0, instr_valid}, 32'd0);
            chk("s3_addr_next", imem_addr, 32'h0000_3104);
    tick(); chk("s3_valid", {31'd0, instr_valid}, 32'd1);
            chk("s3_pc",    pc,    32'h0000_3100);
            chk("s3_instr", instr, 32'hDEAD_3100);

    // redirect coinciding with rvalid and pop (one in flight -> nothing left to drop)
    redirect = 1'b1; npc = 32'h0000_3200;
    tick(); redirect = 1'b0;
    chk("s4a_flush", {31'd0, instr_valid}, 32'd0);
    chk("s4a_npc",   imem_addr, 32'h0000_3200);
    tick(); chk("s4a_nostale", {31'd0, instr_valid}, 32'd0);
            chk("s4a_addr",    imem_addr, 32'h0000_3204);
    tick(); chk("s4a_pc0", pc, 32'h0000_3200);
    tick(); chk("s4a_pc1", pc, 32'h0000_3204);
            chk("s4a_instr1", instr, 32'hDEAD_3204);

    // redirect coinciding with rvalid while two in flight -> one further response dropped
    rv_en = 1'b0;
    tick(); chk("s4b_empty", {31'd0, instr_valid}, 32'd0);
    tick(); chk("s4b_addr",  imem_addr, 32'h0000_3210);
            chk("s4b_full",  {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; npc = 32'h0000_3300; rv_en = 1'b1;
    tick(); redirect = 1'b0;
    chk("s4b_npc",   imem_addr, 32'h0000_3300);
    chk("s4b_flush", {31'd0, instr_valid}, 32'd0);
    tick(); chk("s4b_dropped", {31'd0, instr_valid}, 32'd0);
            chk("s4b_issue",   imem_addr, 32'h0000_3304);
    tick(); chk("s4b_valid", {31'd0, instr_valid}, 32'd1);
            chk("s4b_pc",    pc,    32'h0000_3300);
            chk("s4b_instr", instr, 32'hDEAD_3300);

    // fetch address wraps past 0xFFFF_FFFC
    redirect = 1'b1; npc = 32'hFFFF_FFFC;
    tick(); redirect = 1'b0;
    chk("s5_npc", imem_addr, 32'hFFFF_FFFC);
    tick(); chk("s5_wrap", imem_addr, 32'h0000_0000);
    tick(); chk("s5_pc_top",    pc,    32'hFFFF_FFFC);
            chk("s5_instr_top", instr, 32'h2152_FFFC);
            chk("s5_addr4",     imem_addr, 32'h0000_0004);
    tick(); chk("s5_pc_zero",    pc,    32'h0000_0000);
            chk("s5_instr_zero", instr, 32'hDEAD_0000);

    // misaligned redirect target
    redirect = 1'b1; npc = 32'h0000_3102; #1;
    chk("s6_req_redir", {31'd0, imem_req}, 32'd0);
    tick(); redirect = 1'b0; #1;
`ifdef IF_MISALIGN_TRAP_EN
    chk("s6_mis_set",  {31'd0, misalign},    32'd1);
    chk("s6_halt_req", {31'd0, imem_req},    32'd0);
    chk("s6_flush",    {31'd0, instr_valid}, 32'd0);
    tick(); tick(); #1;
    chk("s6_halt_req2", {31'd0, imem_req}, 32'd0);
    chk("s6_mis_hold",  {31'd0, misalign}, 32'd1);
    redirect = 1'b1; npc = 32'h0000_3200;
    tick(); redirect = 1'b0; #1;
    chk("s6_mis_clr", {31'd0, misalign}, 32'd0);
    chk("s6_resume",  imem_addr, 32'h0000_3200);
    chk("s6_req_on",  {31'd0, imem_req}, 32'd1);
    tick(); tick();
    chk("s6_pc", pc, 32'h0000_3200);
    chk("s6_instr", instr, 32'hDEAD_3200);
`else
    chk("s6_mis_zero", {31'd0, misalign},    32'd0);
    chk("s6_aligned",  imem_addr, 32'h0000_3100);
    chk("s6_flush",    {31'd0, instr_valid}, 32'd0);
    tick(); chk("s6_addr", imem_addr, 32'h0000_3104);
    tick(); chk("s6_pc",    pc,    32'h0000_3100);
            chk("s6_instr", instr, 32'hDEAD_3100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
